// File: rtl/ex_stage.sv
// ex_stage: RV32I execute stage with the EX/MEM pipeline register.
// Selects forwarded operands, runs the ALU, derives {Z,N,V,C}, resolves
// conditional branches and registers everything for the MEM stage.
// Optional feature macro: FORWARDING_EN. When it is defined, forwA/forwB
// drive the operand muxes. Otherwise the operands come straight from ID/EX.
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            idex_valid,
    input  logic [6:0]      idex_op,
    input  logic [2:0]      idex_f3,
    input  logic [3:0]      idex_aluOp,
    input  logic [4:0]      idex_ctrl,
    input  logic [4:0]      idex_rd,
    input  logic [XLEN-1:0] idex_pc,
    input  logic [XLEN-1:0] idex_imm,
    input  logic [XLEN-1:0] idex_op1,
    input  logic [XLEN-1:0] idex_op2,
    input  logic [XLEN-1:0] idex_sdata,
    input  logic [1:0]      forwA,
    input  logic [1:0]      forwB,
    input  logic [XLEN-1:0] memwb_result,
    input  logic            stall,
    input  logic            flush,
    output logic            exmem_valid,
    output logic [XLEN-1:0] exmem_result,
    output logic [3:0]      exmem_flags,
    output logic [XLEN-1:0] exmem_sdata,
    output logic [4:0]      exmem_ctrl,
    output logic [4:0]      exmem_rd,
    output logic            exmem_br_taken,
    output logic [XLEN-1:0] exmem_br_target
);

    // RV32I major opcodes
    localparam logic [6:0] R_TYPE  = 7'b0110011;
    localparam logic [6:0] I_IMM   = 7'b0010011;
    localparam logic [6:0] I_LOAD  = 7'b0000011;
    localparam logic [6:0] S_TYPE  = 7'b0100011;
    localparam logic [6:0] B_TYPE  = 7'b1100011;
    localparam logic [6:0] U_LUI   = 7'b0110111;
    localparam logic [6:0] U_AUIPC = 7'b0010111;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_XOR  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [XLEN-1:0] ZERO_W = {XLEN{1'b0}};

    logic [XLEN-1:0] op_a_s;
    logic [XLEN-1:0] op_b_s;
    logic [XLEN-1:0] st_data_s;
    logic [XLEN-1:0] alu_res_s;
    logic            alu_c_s;
    logic            alu_v_s;
    logic [3:0]      flags_s;
    logic [XLEN-1:0] cmp_diff_s;
    logic            cmp_z_s;
    logic            cmp_n_s;
    logic            cmp_v_s;
    logic            cmp_c_s;
    logic            br_taken_s;
    logic [XLEN-1:0] br_target_s;

`ifdef FORWARDING_EN
    logic [XLEN-1:0] fwd_b_val_s;

    // Operand A source: ID/EX, own EX/MEM register, MEM/WB, or zero
    always_comb begin
        op_a_s = idex_op1;
        case (forwA)
            2'b00:   op_a_s = idex_op1;
            2'b01:   op_a_s = exmem_result;
            2'b10:   op_a_s = memwb_result;
            default: op_a_s = ZERO_W;
        endcase
    end

    // Operand B / store data replacement; which field is replaced depends on the opcode
    always_comb begin
        op_b_s      = idex_op2;
        st_data_s   = idex_sdata;
        fwd_b_val_s = (forwB == 2'b01) ? exmem_result : memwb_result;
        case (forwB)
            2'b00: begin
                op_b_s    = idex_op2;
                st_data_s = idex_sdata;
            end
            2'b01, 2'b10: begin
                case (idex_op)
                    R_TYPE, B_TYPE: op_b_s = fwd_b_val_s;
                    S_TYPE:         st_data_s = fwd_b_val_s;
                    I_IMM, I_LOAD: begin
                        op_b_s    = idex_op2;
                        st_data_s = idex_sdata;
                    end
                    default: begin
                        op_b_s    = ZERO_W;
                        st_data_s = ZERO_W;
                    end
                endcase
            end
            default: begin
                op_b_s    = ZERO_W;
                st_data_s = ZERO_W;
            end
        endcase
    end
`else
    // Forward selects are don't-care here; the hazard unit stalls every RAW hazard
    logic unused_fwd_s;
    assign unused_fwd_s = ^{forwA, forwB, memwb_result};

    // Operands straight from ID/EX
    always_comb begin
        op_a_s    = idex_op1;
        op_b_s    = idex_op2;
        st_data_s = idex_sdata;
    end
`endif

    // ALU result plus carry/overflow for ADD and SUB
    always_comb begin
        alu_res_s = ZERO_W;
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        case (idex_aluOp)
            ALU_ADD: begin
                alu_res_s = op_a_s + op_b_s;
                alu_c_s   = (alu_res_s < op_a_s) || (alu_res_s < op_b_s);
                alu_v_s   = (op_a_s[XLEN-1] == op_b_s[XLEN-1]) &&
                            (alu_res_s[XLEN-1] != op_a_s[XLEN-1]);
            end
            ALU_SUB: begin
                alu_res_s = op_a_s - op_b_s;
                alu_c_s   = (op_a_s >= op_b_s);
                alu_v_s   = (op_a_s[XLEN-1] != op_b_s[XLEN-1]) &&
                            (alu_res_s[XLEN-1] != op_a_s[XLEN-1]);
            end
            ALU_XOR:  alu_res_s = op_a_s ^ op_b_s;
            ALU_OR:   alu_res_s = op_a_s | op_b_s;
            ALU_AND:  alu_res_s = op_a_s & op_b_s;
            ALU_SLL:  alu_res_s = op_a_s << op_b_s[4:0];
            ALU_SRL:  alu_res_s = op_a_s >> op_b_s[4:0];
            ALU_SRA:  alu_res_s = $unsigned($signed(op_a_s) >>> op_b_s[4:0]);
            ALU_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(op_a_s) < $signed(op_b_s))};
            ALU_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (op_a_s < op_b_s)};
            default:  alu_res_s = ZERO_W;
        endcase
        flags_s = {(alu_res_s == ZERO_W), alu_res_s[XLEN-1], alu_v_s, alu_c_s};
    end

    // Branch compare always uses subtract flags, independent of the selected aluOp
    always_comb begin
        cmp_diff_s = op_a_s - op_b_s;
        cmp_z_s    = (cmp_diff_s == ZERO_W);
        cmp_n_s    = cmp_diff_s[XLEN-1];
        cmp_v_s    = (op_a_s[XLEN-1] != op_b_s[XLEN-1]) &&
                     (cmp_diff_s[XLEN-1] != op_a_s[XLEN-1]);
        cmp_c_s    = (op_a_s >= op_b_s);
        br_target_s = idex_pc + idex_imm;
        br_taken_s = 1'b0;
        if (idex_ctrl[0] && (idex_op == B_TYPE)) begin
            case (idex_f3)
                3'b000:  br_taken_s = cmp_z_s;
                3'b001:  br_taken_s = !cmp_z_s;
                3'b100:  br_taken_s = cmp_n_s ^ cmp_v_s;
                3'b101:  br_taken_s = !(cmp_n_s ^ cmp_v_s);
                3'b110:  br_taken_s = !cmp_c_s;
                3'b111:  br_taken_s = cmp_c_s;
                default: br_taken_s = 1'b0;
            endcase
        end else begin
            br_taken_s = 1'b0;
        end
    end

    // EX/MEM register: reset > flush (bubble) > stall (hold) > load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exmem_valid     <= 1'b0;
            exmem_result    <= ZERO_W;
            exmem_flags     <= 4'b0000;
            exmem_sdata     <= ZERO_W;
            exmem_ctrl      <= 5'b00000;
            exmem_rd        <= 5'b00000;
            exmem_br_taken  <= 1'b0;
            exmem_br_target <= ZERO_W;
        end else if (flush) begin
            exmem_valid     <= 1'b0;
            exmem_result    <= ZERO_W;
            exmem_flags     <= 4'b0000;
            exmem_sdata     <= ZERO_W;
            exmem_ctrl      <= 5'b00000;
            exmem_rd        <= 5'b00000;
            exmem_br_taken  <= 1'b0;
            exmem_br_target <= ZERO_W;
        end else if (!stall) begin
            exmem_valid     <= idex_valid;
            exmem_result    <= alu_res_s;
            exmem_flags     <= flags_s;
            exmem_sdata     <= st_data_s;
            exmem_ctrl      <= idex_valid ? idex_ctrl : 5'b00000;
            exmem_rd        <= idex_rd;
            exmem_br_taken  <= idex_valid & br_taken_s;
            exmem_br_target <= br_target_s;
        end
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RV32I pipeline, plus the EX/MEM pipeline register. It takes the ID/EX operands and control, applies the forwarding selects from the hazard unit, and computes the ALU result, flags and branch decision. It then registers everything for the MEM stage. Downstream consumers are data memory, writeback, and the PC-redirect logic in IF.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- idex_valid  in  1  ID/EX holds a real instruction
- idex_op  in  7  opcode (`R_TYPE`, `I_IMM`, `I_LOAD`, `S_TYPE`, `B_TYPE`, `U_LUI`, `U_AUIPC`)
- idex_f3  in  3  funct3; selects the branch condition
- idex_aluOp  in  4  `ALU_*` code from constant_def.vh
- idex_ctrl  in  5  controls: [4] memRead, [3] memWrite, [2] regWrite, [0] branch
- idex_rd  in  5  destination register
- idex_pc  in  32  instruction PC
- idex_imm  in  32  sign-extended immediate
- idex_op1, idex_op2, idex_sdata  in  32 each  operand 1, operand 2, store data
- forwA, forwB  in  2 each  forward selects: 00 none, 01 EX/MEM, 10 MEM/WB
- memwb_result  in  32  writeback value for MEM/WB forwarding
- stall  in  1  hold the EX/MEM register
- flush  in  1  load a bubble into EX/MEM
- exmem_valid  out  1  EX/MEM holds a real instruction
- exmem_result  out  32  ALU result
- exmem_flags  out  4  {Z, N, V, C}
- exmem_sdata  out  32  store data
- exmem_ctrl  out  5  controls, passed through
- exmem_rd  out  5  destination register
- exmem_br_taken  out  1  branch resolved as taken
- exmem_br_target  out  32  idex_pc + idex_imm

## Operation
Forwarding, operand A:
- forwA=00: idex_op1. 01: exmem_result, the block's own register. 10: memwb_result. 11: 0.

Forwarding, operand B and store data, by forwB and opcode:
- forwB=00: no replacement.
- forwB=01: R_TYPE and B_TYPE replace op2 with exmem_result. S_TYPE replaces sdata with exmem_result. I_IMM and I_LOAD leave both unchanged. Any other opcode zeroes op2 and sdata.
- forwB=10: same opcode rules, using memwb_result.
- forwB=11: op2 and sdata both forced to 0.

ALU:
- Operations: ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU.
- Shift amount is B[4:0]. SRA is arithmetic. SLT is signed; SLTU is unsigned.
- Any other aluOp code gives result 0.

Flags:
- ADD: C = (res < A) || (res < B); V = (A[31]==B[31]) && (res[31]!=A[31]).
- SUB: C = (A >= B) unsigned (no-borrow); V = (A[31]!=B[31]) && (res[31]!=A[31]).
- All other operations: C = V = 0.
- N = res[31]; Z = (res == 0).

Branch decision, when ctrl[0]=1 and op=B_TYPE, using the SUB flags:
- f3=000 BEQ: Z. 001 BNE: !Z.
- 100 BLT: N^V. 101 BGE: !(N^V).
- 110 BLTU: !C. 111 BGEU: C.
- Any other f3: not taken.

Register update priority (reset > flush > stall > load):
- Load: captures all computed values.
- idex_valid=0 still loads, with exmem_valid=0, ctrl=0 and br_taken=0. The data fields load normally.
- Flush: valid, ctrl and br_taken go to 0, rd to 0, all data fields to 0.
- Stall: all outputs hold. A stall with no flush must not change exmem_result, because it is the forward source.

## Timing
- Reset: every output is 0, asynchronously on reset assertion. Outputs stay 0 until the first rising edge after reset deassertion.
- Latency: one cycle from ID/EX inputs to EX/MEM outputs. The ALU and forward muxes are combinational inside the cycle.
- EX/MEM forward: the feedback path uses the register value as it stands before the edge. Back-to-back dependent instructions therefore get the previous instruction's result.
- Simultaneous flush and stall: the flush wins and a bubble is loaded.
- Reset mid-stall: the register clears immediately; the held value is lost.
- There is no backpressure handshake; stall and flush come from the hazard unit.

## Configuration
- FORWARDING_EN defined: forwA/forwB muxing as described above.
- FORWARDING_EN undefined: forwA/forwB are ignored, and operands are taken directly from idex_op1, idex_op2 and idex_sdata. The hazard unit is then responsible for stalling every RAW hazard.

## Test plan
- Reset: assert reset during a loaded state → all outputs 0 at once; exmem_valid=0.
- R_TYPE SUB, op1=5, op2=7, forwA=forwB=00 → next cycle result=0xFFFFFFFE, flags N=1 Z=0 V=0 C=0.
- Back-to-back forward: ADD 0xFFFFFFFF+1, then R_TYPE ADD with forwA=01, op2=3 → first result 0 (Z=1 C=1), second result 3.
- S_TYPE with forwB=10, memwb_result=0xDEADBEEF, imm op2=8 → exmem_sdata=0xDEADBEEF, result=op1+8.
- BLT with op1=0x80000000, op2=1 → exmem_br_taken=1, br_target=pc+imm. BLTU with the same operands → taken=0.
- Stall with flush asserted in the same cycle → bubble: valid=0, ctrl=0. Stall alone for 3 cycles → result held.
- FORWARDING_EN undefined: forwA=01 → operand A still equals idex_op1.
